ysyx_22050243_ifu: RTL

Parametrised instruction-fetch unit that replaces the single-register IF stage of the 5-stage core. It owns the PC, issues pipelined in-order fetch requests to the instruction bus with a credit limit, and buffers responses in a FIFO of configurable depth. It presents a valid/ready instruction stream to ID and handles redirects (branch, jump, trap, mret) by flushing the buffer and discarding stale in-flight responses.

---
 rtl/ysyx_22050243_pkg.sv | 17 +
 rtl/ysyx_22050243_sync_fifo.sv | 77 +++++++
 rtl/ysyx_22050243_ifu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050243_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050243_pkg
//   Shared definitions for the instruction-fetch unit:
//     if_exc_e          - cause code attached to every instruction handed to ID
//     RESET_PC_DEFAULT  - default PC loaded on reset
// ----------------------------------------------------------------------------
package ysyx_22050243_pkg;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_ACCESS   = 2'b01,
    EXC_MISALIGN = 2'b10
  } if_exc_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22050243_sync_fifo.sv
// ----------------------------------------------------------------------------
// ysyx_22050243_sync_fifo
//   Single-clock FIFO with a combinational head read (first-word fall-through
//   from storage; a pushed word becomes visible the cycle after the push).
//   Ports:
//     clk, rst     - clock, asynchronous active-high reset (pointers/count)
//     flush_i      - empty the FIFO; takes priority over push/pop
//     push_i/data_i- write one word
//     pop_i        - remove the head word (caller never pops when empty)
//     data_o       - head word
//     count_o      - occupancy, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module ysyx_22050243_sync_fifo
  import ysyx_22050243_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i  && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; consumers qualify the head with count_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ysyx_22050243_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22050243_ifu
//   Instruction-fetch unit: owns the PC, issues pipelined in-order fetches
//   under a credit limit, buffers responses and presents a valid/ready stream
//   to ID. Redirects flush the buffer and mark in-flight responses as stale.
//
//   Ports:
//     clk, rst                      - clock, asynchronous active-high reset
//     inst_req_o / inst_addr_o      - fetch request (registered outputs)
//     inst_req_ready_i              - bus accepts the request this cycle
//     inst_rsp_valid_i/_data_i/_err_i - in-order response, bus error flag
//     redirect_valid_i/redirect_pc_i  - flush and restart fetch
//     id_ready_i                    - ID consumes the head entry
//     if_valid_o/if_inst_o/if_pc_o/if_exc_o - head entry to ID
//
//   Build option YSYX_22050243_IFU_MISALIGN_EN: a misaligned fetch PC produces
//   a single misaligned-exception entry and halts fetch until a redirect.
//   Without it the low two address bits are forced to zero.
// ----------------------------------------------------------------------------
module ysyx_22050243_ifu
  import ysyx_22050243_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter int unsigned           INST_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  inst_req_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  input  logic                  inst_req_ready_i,
  input  logic                  inst_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] inst_rsp_data_i,
  input  logic                  inst_rsp_err_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  id_ready_i,
  output logic                  if_valid_o,
  output logic [INST_WIDTH-1:0] if_inst_o,
  output logic [ADDR_WIDTH-1:0] if_pc_o,
  output logic [1:0]            if_exc_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = ADDR_WIDTH + INST_WIDTH + 2;

`ifdef YSYX_22050243_IFU_MISALIGN_EN
  localparam logic [ADDR_WIDTH-1:0] PC_MASK = '1;
`else
  localparam logic [ADDR_WIDTH-1:0] PC_MASK = ~ADDR_WIDTH'(3);
`endif

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic                  req_q, req_d;
  logic                  halted_q, halted_d;

  logic [CW-1:0]         fifo_cnt, fifo_cnt_d, pend_cnt;
  logic [SW-1:0]         credit_sum_d;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic [EW-1:0]         out_wdata, out_rdata;
  logic                  accept, rsp, rsp_keep, mis_push, out_push, out_pop;
  if_exc_e               rsp_exc;

  assign accept   = req_q && inst_req_ready_i;
  // Responses with nothing pending belong to requests issued before a reset.
  assign rsp      = inst_rsp_valid_i && (pend_cnt != '0);
  assign rsp_keep = rsp && (discard_q == '0) && !redirect_valid_i;
  assign out_pop  = if_valid_o && id_ready_i && !redirect_valid_i;
  assign rsp_exc  = inst_rsp_err_i ? EXC_ACCESS : EXC_NONE;

`ifdef YSYX_22050243_IFU_MISALIGN_EN
  // Waiting for the bus to drain keeps the exception entry in program order
  // and guarantees it never collides with a response push.
  assign mis_push = !halted_q && (fetch_pc_q[1:0] != 2'b00) &&
                    (inflight_q == '0) && (fifo_cnt < CW'(FIFO_DEPTH)) &&
                    !redirect_valid_i;
  assign out_wdata = mis_push ? {fetch_pc_q, INST_WIDTH'(0), EXC_MISALIGN}
                              : {pend_pc, inst_rsp_data_i, rsp_exc};
`else
  assign mis_push  = 1'b0;
  assign out_wdata = {pend_pc, inst_rsp_data_i, rsp_exc};
`endif

  assign out_push = rsp_keep || mis_push;

  always_comb begin
    inflight_d = inflight_q + CW'(accept) - CW'(rsp);
    discard_d  = discard_q;
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    fifo_cnt_d = fifo_cnt + CW'(out_push) - CW'(out_pop);

    if (rsp && (discard_q != '0)) discard_d = discard_q - CW'(1);
    if (accept)                   fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    if (mis_push)                 halted_d = 1'b1;

    // Everything still outstanding after this cycle's bookkeeping is stale.
    if (redirect_valid_i) begin
      fifo_cnt_d = '0;
      discard_d  = inflight_d;
      fetch_pc_d = redirect_pc_i & PC_MASK;
      halted_d   = 1'b0;
    end

    // Request is registered, so it is decided from next-cycle occupancy.
    credit_sum_d = SW'(fifo_cnt_d) + SW'(inflight_d);
    req_d        = !halted_d && (credit_sum_d < SW'(FIFO_DEPTH));
`ifdef YSYX_22050243_IFU_MISALIGN_EN
    if (fetch_pc_d[1:0] != 2'b00) req_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC & PC_MASK;
      inflight_q <= '0;
      discard_q  <= '0;
      req_q      <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      req_q      <= req_d;
      halted_q   <= halted_d;
    end
  end

  // PCs of accepted requests; popped by every response, stale or not, so it
  // stays aligned with the bus and is never flushed by a redirect.
  ysyx_22050243_sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_pend_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (1'b0),
    .push_i  (accept),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp),
    .data_o  (pend_pc),
    .count_o (pend_cnt)
  );

  ysyx_22050243_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_out_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid_i),
    .push_i  (out_push),
    .data_i  (out_wdata),
    .pop_i   (out_pop),
    .data_o  (out_rdata),
    .count_o (fifo_cnt)
  );

  assign inst_req_o  = req_q;
  assign inst_addr_o = fetch_pc_q;
  assign if_valid_o  = (fifo_cnt != '0);
  assign {if_pc_o, if_inst_o, if_exc_o} = if_valid_o ? out_rdata : '0;

endmodule
